// File: rtl/sr_flag_arbiter.sv
// Round-robin arbitrated write port for a bank of set/reset flags.
// One granted command per clock; invalid commands are consumed and flagged on err.
module sr_flag_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_FLAGS = 8,
    parameter int IDX_W     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     op,
    input  logic [IDX_W*NUM_REQ-1:0] idx,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_FLAGS-1:0]     q,
    output logic [NUM_FLAGS-1:0]     qbar,
    output logic                     err,
    output logic                     busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     ptr_next;
    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   gnt_next;
    logic                 found;
    logic [1:0]           sel_op;
    logic [IDX_W-1:0]     sel_idx;
    logic                 cmd_ok;
    logic [NUM_FLAGS-1:0] q_next;

    // The requester granted last cycle is masked so it can drop req without a double grant.
    assign elig = req & ~gnt;
    assign busy = |elig;
    assign qbar = ~q;

    always_comb begin
        int cand;
        cand     = 0;
        found    = 1'b0;
        gnt_next = '0;
        sel_op   = 2'b00;
        sel_idx  = '0;
        ptr_next = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ)
                cand = cand - NUM_REQ;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && k == cand && elig[k]) begin
                    found       = 1'b1;
                    gnt_next[k] = 1'b1;
                    sel_op      = op[2*k +: 2];
                    sel_idx     = idx[IDX_W*k +: IDX_W];
                    ptr_next    = (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
                end
            end
        end
    end

    always_comb begin
        cmd_ok = (sel_op != 2'b11) && (32'(sel_idx) < NUM_FLAGS);
        q_next = q;
        if (found && cmd_ok && sel_op != 2'b00) begin
            for (int f = 0; f < NUM_FLAGS; f++) begin
                if (32'(sel_idx) == f)
                    q_next[f] = sel_op[1];
            end
        end
    end

    // Grant, error pulse and bank write all land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt    <= '0;
            err    <= 1'b0;
            rr_ptr <= '0;
            q      <= '0;
        end else begin
            gnt    <= gnt_next;
            err    <= found && !cmd_ok;
            rr_ptr <= ptr_next;
            q      <= q_next;
        end
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed-vector bench for sr_flag_arbiter: reset, set, invalid, round robin, conflict, hold/idle.
module tb_sr_flag_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int NUM_FLAGS = 8;
    localparam int IDX_W     = 4;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [2*NUM_REQ-1:0]     op;
    logic [IDX_W*NUM_REQ-1:0] idx;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_FLAGS-1:0]     q;
    logic [NUM_FLAGS-1:0]     qbar;
    logic                     err;
    logic                     busy;

    int total = 0;
    int bad   = 0;

    sr_flag_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .NUM_FLAGS(NUM_FLAGS),
        .IDX_W    (IDX_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .op  (op),
        .idx (idx),
        .gnt (gnt),
        .q   (q),
        .qbar(qbar),
        .err (err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int k, input logic [1:0] sr, input int index);
        op[2*k +: 2]         = sr;
        idx[IDX_W*k +: IDX_W] = IDX_W'(index);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < NUM_REQ; k++) set_cmd(k, 2'b10, k);
        req = 4'b1111;
        step();
        total++; if (gnt !== 4'b0001) begin bad++; $display("[TB] FAIL pre_gnt0: got %b expected %b", gnt, 4'b0001); end
        total++; if (q !== 8'h01) begin bad++; $display("[TB] FAIL pre_q0: got %h expected %h", q, 8'h01); end
        step();
        total++; if (q !== 8'h03) begin bad++; $display("[TB] FAIL pre_q1: got %h expected %h", q, 8'h03); end
        #2 rst = 1'b1;
        #1;
        total++; if (q !== 8'h00) begin bad++; $display("[TB] FAIL rst_q: got %h expected %h", q, 8'h00); end
        total++; if (qbar !== 8'hFF) begin bad++; $display("[TB] FAIL rst_qbar: got %h expected %h", qbar, 8'hFF); end
        total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL rst_gnt: got %b expected %b", gnt, 4'b0000); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL rst_err: got %b expected %b", err, 1'b0); end
        for (int k = 0; k < NUM_REQ; k++) set_cmd(k, 2'b00, k);
        #2 rst = 1'b0;
        step();
        total++; if (gnt !== 4'b0001) begin bad++; $display("[TB] FAIL first_gnt: got %b expected %b", gnt, 4'b0001); end
        total++; if (q !== 8'h00) begin bad++; $display("[TB] FAIL first_q: got %h expected %h", q, 8'h00); end
        req = 4'b0000;
        step();
        total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL reset_idle_gnt: got %b expected %b", gnt, 4'b0000); end
    endtask

    task automatic test_single_set();
        set_cmd(2, 2'b10, 3);
        req = 4'b0100;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL set_busy: got %b expected %b", busy, 1'b1); end
        step();
        total++; if (gnt !== 4'b0100) begin bad++; $display("[TB] FAIL set_gnt: got %b expected %b", gnt, 4'b0100); end
        total++; if (q !== 8'h08) begin bad++; $display("[TB] FAIL set_q: got %h expected %h", q, 8'h08); end
        total++; if (qbar !== 8'hF7) begin bad++; $display("[TB] FAIL set_qbar: got %h expected %h", qbar, 8'hF7); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL set_err: got %b expected %b", err, 1'b0); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL set_busy_masked: got %b expected %b", busy, 1'b0); end
        step();
        total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL set_no_double: got %b expected %b", gnt, 4'b0000); end
        total++; if (q !== 8'h08) begin bad++; $display("[TB] FAIL set_q_hold: got %h expected %h", q, 8'h08); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_invalid();
        set_cmd(1, 2'b11, 5);
        req = 4'b0010;
        step();
        total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL inv11_gnt: got %b expected %b", gnt, 4'b0010); end
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL inv11_err: got %b expected %b", err, 1'b1); end
        total++; if (q !== 8'h08) begin bad++; $display("[TB] FAIL inv11_q: got %h expected %h", q, 8'h08); end
        set_cmd(1, 2'b10, 9);
        step();
        total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL inv_gap_gnt: got %b expected %b", gnt, 4'b0000); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL inv_err_pulse: got %b expected %b", err, 1'b0); end
        step();
        total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL oor_gnt: got %b expected %b", gnt, 4'b0010); end
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL oor_err: got %b expected %b", err, 1'b1); end
        total++; if (q !== 8'h08) begin bad++; $display("[TB] FAIL oor_q: got %h expected %h", q, 8'h08); end
        req = 4'b0000;
        step();
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL inv_err_clear: got %b expected %b", err, 1'b0); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        logic [7:0] exp_q [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_q = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0F};
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) set_cmd(k, 2'b10, k);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step();
            total++; if (gnt !== exp_g[n]) begin bad++; $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", n, gnt, exp_g[n]); end
            total++; if (q !== exp_q[n]) begin bad++; $display("[TB] FAIL rr_q[%0d]: got %h expected %h", n, q, exp_q[n]); end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_conflict();
        do_reset();
        set_cmd(0, 2'b10, 6);
        set_cmd(1, 2'b01, 6);
        req = 4'b0011;
        step();
        total++; if (gnt !== 4'b0001) begin bad++; $display("[TB] FAIL cf_gnt0: got %b expected %b", gnt, 4'b0001); end
        total++; if (q !== 8'h40) begin bad++; $display("[TB] FAIL cf_q0: got %h expected %h", q, 8'h40); end
        total++; if (qbar !== 8'hBF) begin bad++; $display("[TB] FAIL cf_qbar0: got %h expected %h", qbar, 8'hBF); end
        req = 4'b0010;
        step();
        total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL cf_gnt1: got %b expected %b", gnt, 4'b0010); end
        total++; if (q !== 8'h00) begin bad++; $display("[TB] FAIL cf_q1: got %h expected %h", q, 8'h00); end
        total++; if (qbar !== 8'hFF) begin bad++; $display("[TB] FAIL cf_qbar1: got %h expected %h", qbar, 8'hFF); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_hold_idle();
        set_cmd(3, 2'b00, 2);
        req = 4'b1000;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL hold_busy: got %b expected %b", busy, 1'b1); end
        step();
        total++; if (gnt !== 4'b1000) begin bad++; $display("[TB] FAIL hold_gnt: got %b expected %b", gnt, 4'b1000); end
        total++; if (q !== 8'h00) begin bad++; $display("[TB] FAIL hold_q: got %h expected %h", q, 8'h00); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL hold_err: got %b expected %b", err, 1'b0); end
        req = 4'b0000;
        for (int n = 0; n < 5; n++) begin
            step();
            total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy[%0d]: got %b expected %b", n, busy, 1'b0); end
            total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL idle_gnt[%0d]: got %b expected %b", n, gnt, 4'b0000); end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        op  = '0;
        idx = '0;
        #12 rst = 1'b0;
        test_reset();
        test_single_set();
        test_invalid();
        test_round_robin();
        test_conflict();
        test_hold_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Shared bank of NUM_FLAGS set/reset flag flops with registered, complementary q/qbar outputs.
- Up to NUM_REQ requesters issue set/reset/hold commands to the bank.
- A round-robin arbiter grants one command per clock.
- This is the controller that serialises and polices every write to the bank, including rejection of the invalid S=R=1 command.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- NUM_FLAGS, 8, number of flag bits in the bank; 2..32.
- IDX_W, 3, width of a flag index; must satisfy 2**IDX_W >= NUM_FLAGS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; held high until granted.
- op  input  2*NUM_REQ  per-requester command {s,r}; requester k uses bits [2k+1:2k].
- idx  input  IDX_W*NUM_REQ  per-requester target flag index; requester k uses bits [IDX_W*k +: IDX_W].
- gnt  output  NUM_REQ  registered one-hot grant; one-cycle pulse.
- q  output  NUM_FLAGS  flag bank state.
- qbar  output  NUM_FLAGS  always the bitwise inverse of q.
- err  output  1  registered one-cycle pulse on a rejected grant.
- busy  output  1  high while any eligible req is pending.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: q=0, qbar=all ones, gnt=0, err=0, rr_ptr=0. rst takes effect immediately, without waiting for a clock edge, and overrides any in-flight grant.
- Command encoding ({s,r}):
  - 00 hold: the grant is consumed, the flag is unchanged.
  - 01 reset: q[idx] <= 0.
  - 10 set: q[idx] <= 1.
  - 11 invalid: flag unchanged, err pulses.
- Index out of range (idx >= NUM_FLAGS): treated as invalid. Flag unchanged, grant still issued, err pulses.
- Eligibility: requester k is eligible when req[k]=1 and gnt[k]=0 in the current cycle. Masking the just-granted requester prevents a double grant while it drops req.
- Arbitration:
  - Combinational selection of the first eligible requester, scanning from rr_ptr upward modulo NUM_REQ.
  - On the next rising edge:
    - gnt[sel] <= 1 and all other gnt bits <= 0.
    - The command is applied to q in that same edge, so the q update is visible in the same cycle gnt is seen (zero added latency).
    - err is updated in that same edge.
    - rr_ptr <= (sel+1) mod NUM_REQ.
  - No eligible requester: gnt <= 0, err <= 0, rr_ptr unchanged.
- Handshake:
  - The requester holds req, op and idx stable until it samples gnt[k]=1.
  - It may deassert req, or present a new command, in the following cycle.
  - A req dropped before grant is never granted and leaves no state.
  - A single continuously requesting agent receives at most one grant every 2 cycles.
- Fairness: with all NUM_REQ requesting, grants rotate 0,1,...,NUM_REQ-1,0,...; no requester waits more than NUM_REQ grants.
- Same flag, conflicting commands from two requesters: serialised in grant order. The later grant wins, one cycle after the earlier.
- Bank access:
  - Exactly one flag bit can change per cycle; all other bits hold.
  - qbar is derived from the same register as q and is never equal to q.
- busy = |(req & ~gnt), purely combinational.
- Structure: the arbiter states are rr_ptr (clog2(NUM_REQ) bits) plus registered gnt. There is no other FSM.

Test Plan:
- Reset: assert rst mid-cycle while req=4'b1111 -> immediately q=8'h00, qbar=8'hFF, gnt=0, err=0. After release, first grant goes to requester 0.
- Single set: requester 2, op=10, idx=3 -> next edge gnt=4'b0100, q=8'h08, qbar=8'hF7. Requester holds req one more cycle -> no second grant that cycle.
- Invalid command: requester 1, op=11, idx=5, then op=10, idx=9 -> both get gnt=4'b0010 and err=1 pulses; q unchanged at 8'h08.
- Round robin: all four request set on idx 0..3 continuously -> gnt sequence 0001,0010,0100,1000,0001. q=8'h0F after the fourth grant.
- Conflict: requester 0 set idx 6 and requester 1 reset idx 6 together, rr_ptr=0 -> q[6]=1 after first grant, q[6]=0 one cycle later. qbar[6] always equals ~q[6].
- Hold/idle: op=00 from requester 3 -> gnt=4'b1000, q unchanged, err=0. With no req, busy=0 and gnt stays 0 for 5 cycles.
